// File: rtl/branch_resolve_if.sv
// branch_resolve_if
//   Bundles the ID-side push channel, the EX-side resolve channel and the
//   training/flush outputs of branch_resolve.
//
//   Handshake semantics: there is no ready signal. The push and res_valid
//   strobes are single-cycle qualifiers sampled on the rising clock edge.
//   upd_valid and flush are single-cycle registered strobes. redirect_pc is
//   meaningful only while flush is high.
//
//   master : the pipeline side. It drives push/resolve and observes the
//            update and flush outputs.
//   slave  : branch_resolve. It consumes push/resolve and drives the update
//            and flush outputs.
interface branch_resolve_if;
   logic        push;
   logic        if_id_write;
   logic [31:0] push_pc;
   logic        push_pred;
   logic        res_valid;
   logic        res_taken;
   logic [31:0] res_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_result;
   logic        flush;
   logic [31:0] redirect_pc;

   modport master (
      output push, if_id_write, push_pc, push_pred,
             res_valid, res_taken, res_target,
      input  upd_valid, upd_pc, upd_result, flush, redirect_pc
   );

   modport slave (
      input  push, if_id_write, push_pc, push_pred,
             res_valid, res_taken, res_target,
      output upd_valid, upd_pc, upd_result, flush, redirect_pc
   );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve
//   In-order tracker for conditional-branch predictions. Each prediction is
//   queued with its PC. When EX resolves the oldest branch, the block emits
//   a training write for the predictor. On a mispredict it also raises a
//   flush with the corrected fetch address and empties the queue.
//
// Ports:
//   clk, rst     : clock; asynchronous active-high reset
//   bus (slave)  : push/resolve inputs, update/flush outputs (see branch_resolve_if)
//   occupancy    : number of entries held (0..DEPTH)
//   branch_count : resolved branches (wraps at 2^32)
//   miss_count   : mispredicted branches (wraps at 2^32)
//   overflow     : sticky, a push was dropped because the queue was full
//   underflow    : sticky, a resolve arrived while the queue was empty
module branch_resolve #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic               clk,
   input  logic               rst,
   branch_resolve_if.slave    bus,
   output logic [PTR_W:0]     occupancy,
   output logic [31:0]        branch_count,
   output logic [31:0]        miss_count,
   output logic               overflow,
   output logic               underflow
);

   logic [31:0]      mem_pc   [DEPTH];
   logic             mem_pred [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   logic        empty;
   logic        full;
   logic        pop;
   logic        mispredict;
   logic        push_req;
   logic        accept;
   logic        overflow_evt;
   logic        underflow_evt;
   logic [31:0] head_pc;
   logic        head_pred;

   assign head_pc   = mem_pc[rd_ptr];
   assign head_pred = mem_pred[rd_ptr];
   assign empty     = (occupancy == '0);
   // Occupancy never exceeds DEPTH = 2**PTR_W, so the MSB alone marks full.
   assign full      = occupancy[PTR_W];

   assign pop           = bus.res_valid & ~empty;
   assign mispredict    = pop & (bus.res_taken != head_pred);
   assign push_req      = bus.push & bus.if_id_write & ~mispredict;
   // A same-cycle pop frees a slot, so a full queue still accepts the push.
   assign accept        = push_req & (~full | pop);
   assign overflow_evt  = push_req & full & ~pop;
   assign underflow_evt = bus.res_valid & empty;

   // Entry storage has no reset. Stale contents are never read, because
   // occupancy gates every pop.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem_pc[wr_ptr]   <= bus.push_pc;
         mem_pred[wr_ptr] <= bus.push_pred;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else if (mispredict) begin
         // Every younger entry is wrong-path, so the whole queue is dropped.
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         occupancy <= occupancy + {{PTR_W{1'b0}}, accept} - {{PTR_W{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.upd_valid   <= 1'b0;
         bus.upd_pc      <= '0;
         bus.upd_result  <= 1'b0;
         bus.flush       <= 1'b0;
         bus.redirect_pc <= '0;
         branch_count    <= '0;
         miss_count      <= '0;
         overflow        <= 1'b0;
         underflow       <= 1'b0;
      end else begin
         bus.upd_valid <= pop;
         bus.flush     <= mispredict;
         if (pop) begin
            bus.upd_pc     <= head_pc;
            bus.upd_result <= bus.res_taken;
            branch_count   <= branch_count + 32'd1;
         end
         if (mispredict) begin
            bus.redirect_pc <= bus.res_taken ? bus.res_target : head_pc + 32'd4;
            miss_count      <= miss_count + 32'd1;
         end
         if (overflow_evt)  overflow  <= 1'b1;
         if (underflow_evt) underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve
//   Directed testbench for branch_resolve. Inputs are driven 1 ns after the
//   rising edge. Outputs are sampled 1 ns after the next rising edge.
module tb_branch_resolve;

   logic               clk;
   logic               rst;
   logic [2:0]         occupancy;
   logic [31:0]        branch_count;
   logic [31:0]        miss_count;
   logic               overflow;
   logic               underflow;

   int checks   = 0;
   int failures = 0;

   branch_resolve_if bif ();

   branch_resolve #(.DEPTH(4), .PTR_W(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bif.slave),
      .occupancy    (occupancy),
      .branch_count (branch_count),
      .miss_count   (miss_count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic idle_inputs();
      bif.push        = 1'b0;
      bif.if_id_write = 1'b1;
      bif.push_pc     = '0;
      bif.push_pred   = 1'b0;
      bif.res_valid   = 1'b0;
      bif.res_taken   = 1'b0;
      bif.res_target  = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle with an optional push and an optional resolve, then back to idle inputs.
   task automatic step(input logic p, input logic ifw, input logic [31:0] pc, input logic pred,
                       input logic rv, input logic rt, input logic [31:0] tgt);
      bif.push        = p;
      bif.if_id_write = ifw;
      bif.push_pc     = pc;
      bif.push_pred   = pred;
      bif.res_valid   = rv;
      bif.res_taken   = rt;
      bif.res_target  = tgt;
      tick();
      idle_inputs();
   endtask

   task automatic do_push(input logic [31:0] pc, input logic pred);
      step(1'b1, 1'b1, pc, pred, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic do_res(input logic rt, input logic [31:0] tgt);
      step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, rt, tgt);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_upd_valid"},   {31'd0, bif.upd_valid},  32'd0);
      chk({tag, "_upd_pc"},      bif.upd_pc,              32'd0);
      chk({tag, "_upd_result"},  {31'd0, bif.upd_result}, 32'd0);
      chk({tag, "_flush"},       {31'd0, bif.flush},      32'd0);
      chk({tag, "_redirect_pc"}, bif.redirect_pc,         32'd0);
      chk({tag, "_occupancy"},   {29'd0, occupancy},      32'd0);
      chk({tag, "_branch_cnt"},  branch_count,            32'd0);
      chk({tag, "_miss_cnt"},    miss_count,              32'd0);
      chk({tag, "_overflow"},    {31'd0, overflow},       32'd0);
      chk({tag, "_underflow"},   {31'd0, underflow},      32'd0);
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk_all_zero("reset");

      // Correct prediction: push taken, resolve taken.
      do_push(32'h0001_0000, 1'b1);
      chk("push1_occ", {29'd0, occupancy}, 32'd1);
      do_res(1'b1, 32'h0002_0000);
      chk("hit_upd_valid",  {31'd0, bif.upd_valid},  32'd1);
      chk("hit_upd_pc",     bif.upd_pc,              32'h0001_0000);
      chk("hit_upd_result", {31'd0, bif.upd_result}, 32'd1);
      chk("hit_flush",      {31'd0, bif.flush},      32'd0);
      chk("hit_branch_cnt", branch_count,            32'd1);
      chk("hit_occ",        {29'd0, occupancy},      32'd0);
      tick();
      chk("hit_strobe_1cyc", {31'd0, bif.upd_valid}, 32'd0);

      // Mispredict, not taken: redirect to pc+4.
      do_push(32'h0001_0040, 1'b1);
      do_res(1'b0, 32'h0005_0000);
      chk("mnt_flush",    {31'd0, bif.flush}, 32'd1);
      chk("mnt_redirect", bif.redirect_pc,    32'h0001_0044);
      chk("mnt_miss_cnt", miss_count,         32'd1);
      chk("mnt_occ",      {29'd0, occupancy}, 32'd0);
      chk("mnt_upd_res",  {31'd0, bif.upd_result}, 32'd0);
      tick();
      chk("mnt_flush_1cyc", {31'd0, bif.flush}, 32'd0);

      // Mispredict, taken, with three in flight.
      do_push(32'h0000_0100, 1'b0);
      do_push(32'h0000_0104, 1'b0);
      do_push(32'h0000_0108, 1'b0);
      chk("m3_occ_before", {29'd0, occupancy}, 32'd3);
      do_res(1'b1, 32'h0000_0200);
      chk("m3_flush",      {31'd0, bif.flush}, 32'd1);
      chk("m3_redirect",   bif.redirect_pc,    32'h0000_0200);
      chk("m3_upd_pc",     bif.upd_pc,         32'h0000_0100);
      chk("m3_occ_after",  {29'd0, occupancy}, 32'd0);
      chk("m3_miss_cnt",   miss_count,         32'd2);
      chk("m3_branch_cnt", branch_count,       32'd3);
      do_res(1'b1, 32'h0000_0300);
      chk("uf_flag",       {31'd0, underflow},     32'd1);
      chk("uf_upd_valid",  {31'd0, bif.upd_valid}, 32'd0);
      chk("uf_branch_cnt", branch_count,           32'd3);
      chk("uf_flush",      {31'd0, bif.flush},     32'd0);

      // Full queue, then simultaneous events.
      do_push(32'h0000_0300, 1'b1);
      do_push(32'h0000_0304, 1'b1);
      do_push(32'h0000_0308, 1'b1);
      do_push(32'h0000_030c, 1'b1);
      chk("full_occ",      {29'd0, occupancy}, 32'd4);
      chk("full_no_ovf",   {31'd0, overflow},  32'd0);
      do_push(32'h0000_0310, 1'b1);
      chk("ovf_flag",      {31'd0, overflow},  32'd1);
      chk("ovf_occ",       {29'd0, occupancy}, 32'd4);
      step(1'b1, 1'b1, 32'h0000_0314, 1'b0, 1'b1, 1'b1, 32'h0000_0900);
      chk("pp_occ",        {29'd0, occupancy}, 32'd4);
      chk("pp_upd_pc",     bif.upd_pc,         32'h0000_0300);
      chk("pp_flush",      {31'd0, bif.flush}, 32'd0);
      chk("pp_branch_cnt", branch_count,       32'd4);
      do_res(1'b1, 32'h0000_0900);
      chk("pop2_upd_pc",   bif.upd_pc,         32'h0000_0304);
      chk("pop2_occ",      {29'd0, occupancy}, 32'd3);
      step(1'b1, 1'b1, 32'h0000_0318, 1'b1, 1'b1, 1'b0, 32'h0000_0900);
      chk("pm_flush",      {31'd0, bif.flush}, 32'd1);
      chk("pm_redirect",   bif.redirect_pc,    32'h0000_030c);
      chk("pm_occ",        {29'd0, occupancy}, 32'd0);
      chk("pm_miss_cnt",   miss_count,         32'd3);
      chk("pm_branch_cnt", branch_count,       32'd6);
      chk("pm_ovf_sticky", {31'd0, overflow},  32'd1);

      // Stall blocks the push.
      step(1'b1, 1'b0, 32'h0000_0400, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("stall_occ",     {29'd0, occupancy}, 32'd0);
      do_push(32'h0000_0400, 1'b1);
      do_push(32'h0000_0404, 1'b1);
      chk("prerst_occ",    {29'd0, occupancy}, 32'd2);

      // Asynchronous reset mid-cycle while a resolve is pending.
      bif.res_valid = 1'b1;
      bif.res_taken = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      tick();
      rst = 1'b0;
      idle_inputs();
      tick();
      chk("postrst_upd_valid", {31'd0, bif.upd_valid}, 32'd0);
      chk("postrst_occ",       {29'd0, occupancy},     32'd0);
      chk("postrst_branch",    branch_count,           32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
